// File: rtl/btree_pkg.sv
// btree_pkg: shared types and the pairwise operator
// used by every node of the reduction tree.
package btree_pkg;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_MAX,
    OP_MIN
  } op_e;

  localparam int MAX_LEAVES = 64;
  localparam int MAX_W      = 128;

  // Operands arrive sign-extended to MAX_W; callers keep the low WIDTH bits.
  function automatic logic signed [MAX_W-1:0] btree_op(
    input op_e                     op,
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b
  );
    logic signed [MAX_W-1:0] r;
    r = a;
    case (op)
      OP_ADD:  r = a + b;
      OP_MAX:  r = (b > a) ? b : a;
      OP_MIN:  r = (b < a) ? b : a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btree_level.sv
// btree_level: one tree level, N_IN/2 pairwise ops
// followed by the register stage carrying valid and tag.
module btree_level
  import btree_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  N_IN  = 2,
  parameter op_e OP    = OP_ADD,
  parameter int  TAG_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv,
  input  logic [N_IN*WIDTH-1:0]     src_data,
  input  logic [TAG_W-1:0]          src_tag,
  input  logic                      src_valid,
  output logic [(N_IN/2)*WIDTH-1:0] data,
  output logic [TAG_W-1:0]          tag,
  output logic                      valid
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*WIDTH-1:0] node;

  always_comb begin
    node = '0;
    for (int j = 0; j < N_OUT; j++) begin
      node[j*WIDTH +: WIDTH] = WIDTH'(btree_op(
        OP,
        MAX_W'(signed'(src_data[(2*j)*WIDTH +: WIDTH])),
        MAX_W'(signed'(src_data[(2*j+1)*WIDTH +: WIDTH]))
      ));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= src_valid;
    end
  end

  // Payload is not reset; valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (adv) begin
      data <= node;
      tag  <= src_tag;
    end
  end

endmodule

// File: rtl/btree_reduce.sv
// btree_reduce: pipelined binary reduction tree with
// valid/ready handshake and a sideband tag per set.
module btree_reduce
  import btree_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  N_LEAVES = 8,
  parameter op_e OP       = OP_ADD,
  parameter int  TAG_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_LEAVES*WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int LEVELS  = $clog2(N_LEAVES);
  localparam int CHAIN_W = (2*N_LEAVES - 1) * WIDTH;

  logic                      adv;
  logic [N_LEAVES*WIDTH-1:0] s0_data;
  logic [TAG_W-1:0]          s0_tag;
  logic                      s0_valid;

  // All stage payloads packed back to back: stage 0 first, root last.
  wire [CHAIN_W-1:0] chain;
  wire [TAG_W-1:0]   tags [LEVELS+1];
  wire [LEVELS:0]    valids;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
    end else if (adv) begin
      s0_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s0_data <= in_data;
      s0_tag  <= in_tag;
    end
  end

  assign chain[N_LEAVES*WIDTH-1:0] = s0_data;
  assign tags[0]                   = s0_tag;
  assign valids[0]                 = s0_valid;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int N_IN    = N_LEAVES >> (k - 1);
    localparam int IN_OFF  = (2*N_LEAVES - 2*N_IN) * WIDTH;
    localparam int OUT_OFF = IN_OFF + N_IN*WIDTH;

    btree_level #(
      .WIDTH (WIDTH),
      .N_IN  (N_IN),
      .OP    (OP),
      .TAG_W (TAG_W)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .src_data  (chain[IN_OFF +: N_IN*WIDTH]),
      .src_tag   (tags[k-1]),
      .src_valid (valids[k-1]),
      .data      (chain[OUT_OFF +: (N_IN/2)*WIDTH]),
      .tag       (tags[k]),
      .valid     (valids[k])
    );
  end

  assign out_data  = chain[CHAIN_W-WIDTH +: WIDTH];
  assign out_tag   = tags[LEVELS];
  assign out_valid = valids[LEVELS];

endmodule

// File: tb/tb_btree_reduce.sv
// tb_btree_reduce: directed bench with a result scoreboard
// for the reduction tree (ADD N=8, MAX/MIN N=4).
module tb_btree_reduce;
  import btree_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  tag;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [255:0] in_data;
  logic [7:0]   in_tag;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic [7:0]   out_tag;
  logic         out_valid;
  logic         out_ready;

  logic [127:0] q_data;
  logic [7:0]   q_tag;
  logic         q_valid;
  logic         q_ready;
  logic         mx_in_ready;
  logic [31:0]  mx_data;
  logic [7:0]   mx_tag;
  logic         mx_valid;
  logic         mn_in_ready;
  logic [31:0]  mn_data;
  logic [7:0]   mn_tag;
  logic         mn_valid;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t e;

  btree_reduce #(
    .WIDTH(32), .N_LEAVES(8), .OP(OP_ADD), .TAG_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  btree_reduce #(
    .WIDTH(32), .N_LEAVES(4), .OP(OP_MAX), .TAG_W(8)
  ) dut_max (
    .clk(clk), .rst(rst),
    .in_data(q_data), .in_tag(q_tag),
    .in_valid(q_valid), .in_ready(mx_in_ready),
    .out_data(mx_data), .out_tag(mx_tag),
    .out_valid(mx_valid), .out_ready(q_ready)
  );

  btree_reduce #(
    .WIDTH(32), .N_LEAVES(4), .OP(OP_MIN), .TAG_W(8)
  ) dut_min (
    .clk(clk), .rst(rst),
    .in_data(q_data), .in_tag(q_tag),
    .in_valid(q_valid), .in_ready(mn_in_ready),
    .out_data(mn_data), .out_tag(mn_tag),
    .out_valid(mn_valid), .out_ready(q_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic logic [255:0] seq8(input logic [31:0] s);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = s + 32'(i);
    return r;
  endfunction

  function automatic logic [255:0] fill8(input logic [31:0] v);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [31:0] sum8(input logic [255:0] d);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + d[i*32 +: 32];
    return s;
  endfunction

  // Offer one set at the current negedge and book its expected result.
  task automatic drive(input logic [255:0] d, input logic [7:0] t,
                       input string nm);
    in_data  = d;
    in_tag   = t;
    in_valid = 1'b1;
    #1;
    chk(nm, in_ready, 1);
    sb.push_back('{data: sum8(d), tag: t});
  endtask

  // Scoreboard side: a result transfers on the next posedge.
  always @(negedge clk) begin
    #2;
    if (out_valid && out_ready) begin
      chk("sb_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data", out_data, e.data);
        chk("sb_tag", out_tag, e.tag);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int idx;
    int stall_cnt;
    bit stalled;
    logic [31:0] held;

    rst       = 1'b1;
    in_data   = '0;
    in_tag    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    q_data    = '0;
    q_tag     = '0;
    q_valid   = 1'b0;
    q_ready   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mx_valid", mx_valid, 0);

    // MAX / MIN over {-5, 3, 0x7FFFFFFF, -1}, latency 3
    @(negedge clk);
    c0 = cyc;
    q_data  = {32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd3, 32'hFFFF_FFFB};
    q_tag   = 8'h33;
    q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mm_early_valid", mx_valid, 0);
    @(negedge clk);
    #1;
    chk("mm_cycle", cyc, c0 + 3);
    chk("max_valid", mx_valid, 1);
    chk("max_data", mx_data, 32'h7FFF_FFFF);
    chk("max_tag", mx_tag, 8'h33);
    chk("min_valid", mn_valid, 1);
    chk("min_data", mn_data, 32'hFFFF_FFFB);

    // Single set 1..8 tag 0x5A: valid for exactly one cycle at +4
    @(negedge clk);
    c0 = cyc;
    drive(seq8(1), 8'h5A, "t1_accept");
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      chk("t1_valid", out_valid, (k == 4));
      if (k == 4) begin
        chk("t1_data", out_data, 32'd36);
        chk("t1_tag", out_tag, 8'h5A);
      end
    end

    // Wrap, then back-to-back sets on consecutive cycles
    @(negedge clk);
    c0 = cyc;
    drive(fill8(32'hFFFF_FFFF), 8'h01, "b2b_acc0");
    @(negedge clk);
    drive(seq8(1), 8'h02, "b2b_acc1");
    @(negedge clk);
    drive(fill8(32'd2), 8'h03, "b2b_acc2");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("wrap_cycle", cyc, c0 + 4);
    chk("wrap_valid", out_valid, 1);
    chk("wrap_data", out_data, 32'hFFFF_FFF8);
    @(negedge clk);
    #1;
    chk("b2b_a_valid", out_valid, 1);
    chk("b2b_a_data", out_data, 32'd36);
    @(negedge clk);
    #1;
    chk("b2b_b_valid", out_valid, 1);
    chk("b2b_b_data", out_data, 32'd16);

    // Backpressure: 6 sets, 3-cycle stall after first result
    idx       = 0;
    stalled   = 1'b0;
    stall_cnt = 0;
    held      = '0;
    for (int c = 0; c < 60 && (idx < 6 || sb.size() != 0); c++) begin
      @(negedge clk);
      if (!stalled && out_valid) begin
        stalled   = 1'b1;
        stall_cnt = 3;
        held      = out_data;
      end
      out_ready = (stall_cnt == 0);
      if (idx < 6) begin
        in_valid = 1'b1;
        in_data  = seq8(32'(idx * 100));
        in_tag   = 8'(idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_cnt > 0) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", out_data, held);
        stall_cnt--;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{data: sum8(in_data), tag: in_tag});
        idx++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_stalled", stalled, 1);
    chk("bp_sent", idx, 6);
    chk("bp_drained", sb.size(), 0);

    // Mid-flight reset: three sets discarded, nothing stale appears
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_data  = fill8(32'(i + 9));
      in_tag   = 8'(8'hE0 + i);
      in_valid = 1'b1;
      #1;
      chk("mr_accept", in_ready, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("mr_ready_in_rst", in_ready, 1);
    chk("mr_valid_in_rst", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("mr_no_stale", out_valid, 0);
    end
    @(negedge clk);
    c0 = cyc;
    drive(seq8(7), 8'h77, "mr_new_accept");
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      chk("mr_new_valid", out_valid, (k == 4));
    end
    chk("mr_new_data", out_data, 32'd84);

    // Bubbles: in_valid 1,0,1 gives out_valid 1,0,1 four cycles later
    @(negedge clk);
    c0 = cyc;
    drive(seq8(20), 8'h10, "bub_acc0");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    drive(seq8(30), 8'h11, "bub_acc1");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("bub_cycle", cyc, c0 + 4);
    chk("bub_v0", out_valid, 1);
    @(negedge clk);
    #1;
    chk("bub_v1", out_valid, 0);
    @(negedge clk);
    #1;
    chk("bub_v2", out_valid, 1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    #3;
    chk("final_drain", sb.size(), 0);
    chk("final_idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btree_reduce.md
Name: btree_reduce

Overview:
- Parametrised, pipelined binary reduction tree.
- Registers N_LEAVES operand words at the input, then combines adjacent pairs level by level, with one register stage per level, to produce one result word.
- Successor to the fixed 8-leaf register-only tree stage. Adds configurable width, leaf count and reduction op, a valid/ready handshake with backpressure, and a sideband tag aligned to each result.
- Sits between wide parallel producers (e.g. per-lane accumulators) and scalar consumers.

Parameters:
- WIDTH, 32: bit width of each operand and of the result.
- N_LEAVES, 8: number of input operands; power of two, 2..64.
- OP, OP_ADD: reduction operator (btree_pkg::op_e). OP_ADD = modulo-2^WIDTH sum; OP_MAX = signed maximum; OP_MIN = signed minimum.
- TAG_W, 8: width of the sideband tag carried alongside each reduction.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  N_LEAVES*WIDTH  packed operands; leaf i = bits [i*WIDTH +: WIDTH]
- in_tag  in  TAG_W  sideband tag for this operand set
- in_valid  in  1  operand set valid
- in_ready  out  1  block accepts the operand set this cycle
- out_data  out  WIDTH  reduction result
- out_tag  out  TAG_W  tag of the set that produced out_data
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result

Behaviour:
- Interface fixed: one clock, clk. Reset rst is synchronous and active-high.
- LEVELS = log2(N_LEAVES). Pipeline = stage 0 (input register) + LEVELS tree stages. Latency from accept to out_valid = LEVELS+1 cycles (4 for the defaults).
- Every stage holds a valid bit, its data and its tag. Data registers are not reset. Valid bits are reset to 0.
- Reset values: out_valid=0. in_ready=1 in the first cycle after reset. out_data/out_tag are don't-care while out_valid=0.
- Global advance enable: adv = !out_valid | out_ready. All stages shift together when adv=1 and hold when adv=0. There are no per-stage bubble-collapse rules.
- in_ready = adv, purely combinational from out_valid and out_ready. The handshake is accepted when in_valid & in_ready.
- Stage 0 captures in_data/in_tag and sets valid=in_valid on adv. A bubble (in_valid=0) propagates as valid=0.
- Tree level k (1..LEVELS) has N_LEAVES>>k nodes. Node j = op(prev[2j], prev[2j+1]), registered on adv. Tag and valid copy from the previous stage.
- OP_ADD: wrap modulo 2^WIDTH, no saturation, no carry-out. OP_MAX/OP_MIN: two's-complement compare; on a tie the left (even-index) operand wins.
- The final stage drives out_data/out_tag/out_valid directly.
- Throughput: one set per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, all stages and out_* hold and in_ready=0. Input sets offered during a stall are not accepted; the producer must hold them.
- Stall with out_valid=0: the pipeline still advances. Bubbles fill, so a full pipeline can form behind a stalled empty output.
- Reset mid-operation: all in-flight sets are discarded, with valids cleared on the clock edge where rst=1. rst dominates adv. in_ready remains combinational (=1 while out_valid=0).
- No X propagation on out_valid. Leaf data with X only affects out_data.

Decomposition:
- Package btree_pkg: typedef enum op_e {OP_ADD, OP_MAX, OP_MIN}; function btree_op(op_e, a, b) parametrised on WIDTH via a localparam or argument; localparam MAX_LEAVES=64.
- Sub-module btree_level (params WIDTH, N_IN, OP, TAG_W). It does N_IN/2 pairwise ops plus the register stage with valid/tag, enabled by adv.
- btree_reduce instantiates the input stage and LEVELS btree_level instances in a generate loop.

Test Plan:
- OP_ADD, N=8, W=32: leaves 1..8, tag 0x5A, out_ready=1 -> 4 cycles later out_valid=1, out_data=36, out_tag=0x5A, for exactly one cycle.
- OP_ADD wrap: leaves all 0xFFFF_FFFF -> out_data=0xFFFF_FFF8. Back-to-back sets A (1..8) and B (all 2) -> results 36 then 16 on consecutive cycles.
- OP_MAX/OP_MIN, N=4: leaves {-5, 3, 0x7FFF_FFFF, -1} -> MAX=0x7FFF_FFFF, MIN=0xFFFF_FFFB.
- Backpressure: stream 6 sets with tags 0..5, hold out_ready=0 for 3 cycles after the first result -> in_ready=0 and out_data held during the stall. All 6 results arrive in order with no loss or duplication.
- Mid-flight reset: accept 3 sets, assert rst for 1 cycle -> out_valid stays 0 and no stale result ever appears. A new set accepted after reset yields its result after exactly LEVELS+1 cycles.
- Bubbles: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 offset by LEVELS+1 cycles.
